// File: rtl/dpr_nxw_clr_if.sv
// Port bundle for dpr_nxw_clr: write, read and clear controls towards the RAM,
// with read data and status flowing back.
`timescale 1ns/1ps
interface dpr_nxw_clr_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              WRE;
  logic [ADDR_W-1:0] WAD;
  logic [DATA_W-1:0] DI;
  logic [ADDR_W-1:0] RAD;
  logic              RE;
  logic              CLR;
  logic [DATA_W-1:0] DO;
  logic              DO_VLD;
  logic              BUSY;
  logic              DROP;

  modport master (
    output WRE, WAD, DI, RAD, RE, CLR,
    input  DO, DO_VLD, BUSY, DROP
  );

  modport slave (
    input  WRE, WAD, DI, RAD, RE, CLR,
    output DO, DO_VLD, BUSY, DROP
  );
endinterface

// File: rtl/dpr_nxw_clr.sv
// Distributed dual-port RAM with one write port, one async or registered read port,
// and a clear sequencer that fills every word with INIT_VAL after reset or on CLR.
`timescale 1ns/1ps
module dpr_nxw_clr #(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit                READ_REG = 1'b0,
  parameter bit                BYPASS   = 1'b1
) (
  input logic           WCK,
  input logic           RSTN,
  dpr_nxw_clr_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic                busy_q;
  logic                drop_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge WCK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= bus.WRE & busy_q;
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (&clr_ptr_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (bus.CLR) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  // The array is deliberately unreset so it maps onto fabric RAM; the clear
  // sequencer provides the known state instead.
  always_ff @(posedge WCK) begin
    if (busy_q) begin
      mem_q[clr_ptr_q] <= INIT_VAL;
    end else if (bus.WRE) begin
      mem_q[bus.WAD] <= bus.DI;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DROP = drop_q;

  generate
    if (READ_REG) begin : gen_rd_reg
      logic [DATA_W-1:0] do_q, do_d;
      logic              vld_q, vld_d;

      always_comb begin
        do_d  = do_q;
        vld_d = 1'b0;
        if (bus.RE && !busy_q) begin
          vld_d = 1'b1;
          if (BYPASS && bus.WRE && (bus.WAD == bus.RAD)) begin
            do_d = bus.DI;
          end else begin
            do_d = mem_q[bus.RAD];
          end
        end
      end

      always_ff @(posedge WCK or negedge RSTN) begin
        if (!RSTN) begin
          do_q  <= '0;
          vld_q <= 1'b0;
        end else begin
          do_q  <= do_d;
          vld_q <= vld_d;
        end
      end

      assign bus.DO     = do_q;
      assign bus.DO_VLD = vld_q;
    end else begin : gen_rd_async
      assign bus.DO     = mem_q[bus.RAD];
      assign bus.DO_VLD = ~busy_q;
    end
  endgenerate
endmodule

// File: tb/tb_dpr_nxw_clr.sv
// Directed bench for dpr_nxw_clr: four instances cover async read, registered read
// with and without bypass, and a wide/deep configuration against a reference array.
`timescale 1ns/1ps
module tb_dpr_nxw_clr;
  logic clk = 1'b0;
  logic rst0_n, rst1_n, rst2_n, rst3_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  dpr_nxw_clr_if #(.DATA_W(4),  .ADDR_W(4)) if0 ();
  dpr_nxw_clr_if #(.DATA_W(4),  .ADDR_W(4)) if1 ();
  dpr_nxw_clr_if #(.DATA_W(4),  .ADDR_W(4)) if2 ();
  dpr_nxw_clr_if #(.DATA_W(18), .ADDR_W(6)) if3 ();

  dpr_nxw_clr #(.DATA_W(4), .ADDR_W(4), .INIT_VAL(4'hA), .READ_REG(1'b0), .BYPASS(1'b1))
    u_dut0 (.WCK(clk), .RSTN(rst0_n), .bus(if0));
  dpr_nxw_clr #(.DATA_W(4), .ADDR_W(4), .INIT_VAL(4'h6), .READ_REG(1'b1), .BYPASS(1'b1))
    u_dut1 (.WCK(clk), .RSTN(rst1_n), .bus(if1));
  dpr_nxw_clr #(.DATA_W(4), .ADDR_W(4), .INIT_VAL(4'h0), .READ_REG(1'b1), .BYPASS(1'b0))
    u_dut2 (.WCK(clk), .RSTN(rst2_n), .bus(if2));
  dpr_nxw_clr #(.DATA_W(18), .ADDR_W(6), .INIT_VAL(18'h2A5A5), .READ_REG(1'b1), .BYPASS(1'b1))
    u_dut3 (.WCK(clk), .RSTN(rst3_n), .bus(if3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
      $display("  ok %s = %0h @%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] ref3 [64];
  logic [17:0] exp_do3;
  logic        exp_vld3;

  initial begin
    {if0.WRE, if0.WAD, if0.DI, if0.RAD, if0.RE, if0.CLR} = '0;
    {if1.WRE, if1.WAD, if1.DI, if1.RAD, if1.RE, if1.CLR} = '0;
    {if2.WRE, if2.WAD, if2.DI, if2.RAD, if2.RE, if2.CLR} = '0;
    {if3.WRE, if3.WAD, if3.DI, if3.RAD, if3.RE, if3.CLR} = '0;
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0; rst3_n = 1'b0;
    tick(); tick();
    chk("rst_busy0", 32'(if0.BUSY), 32'd1);
    chk("rst_vld0", 32'(if0.DO_VLD), 32'd0);
    chk("rst_do1", 32'(if1.DO), 32'd0);
    chk("rst_vld1", 32'(if1.DO_VLD), 32'd0);
    chk("rst_drop1", 32'(if1.DROP), 32'd0);

    // Release all resets together; dut0 clears in 16 edges, dut3 in 64.
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1; rst3_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i <= 16) begin
        chk($sformatf("clr16_busy0_e%0d", i), 32'(if0.BUSY), 32'(i < 16));
        chk($sformatf("clr16_vld0_e%0d", i), 32'(if0.DO_VLD), 32'(i >= 16));
      end
      if (i >= 62) chk($sformatf("clr64_busy3_e%0d", i), 32'(if3.BUSY), 32'(i < 64));
    end

    for (int a = 0; a < 16; a++) begin
      if0.RAD = 4'(a);
      #1;
      chk($sformatf("init_sweep_%0d", a), 32'(if0.DO), 32'hA);
    end

    // Back-to-back writes to one word, observed through the async read port.
    if0.RAD = 4'd5; if0.WRE = 1'b1; if0.WAD = 4'd5; if0.DI = 4'h3;
    tick();
    chk("wr5_first", 32'(if0.DO), 32'h3);
    if0.DI = 4'hC;
    tick();
    if0.WRE = 1'b0;
    chk("wr5_second", 32'(if0.DO), 32'hC);
    chk("idle_drop0", 32'(if0.DROP), 32'd0);

    // Registered read with same-edge write: bypass on dut1, old data on dut2.
    if1.WRE = 1'b1; if1.WAD = 4'd7; if1.DI = 4'h1;
    if2.WRE = 1'b1; if2.WAD = 4'd7; if2.DI = 4'h1;
    tick();
    if1.DI = 4'h9; if1.RE = 1'b1; if1.RAD = 4'd7;
    if2.DI = 4'h9; if2.RE = 1'b1; if2.RAD = 4'd7;
    tick();
    if1.WRE = 1'b0; if1.RE = 1'b0;
    if2.WRE = 1'b0;
    chk("byp1_do", 32'(if1.DO), 32'h9);
    chk("byp1_vld", 32'(if1.DO_VLD), 32'd1);
    chk("nobyp2_do", 32'(if2.DO), 32'h1);
    chk("nobyp2_vld", 32'(if2.DO_VLD), 32'd1);
    tick();
    if2.RE = 1'b0;
    chk("byp1_vld_drop", 32'(if1.DO_VLD), 32'd0);
    chk("byp1_do_hold", 32'(if1.DO), 32'h9);
    chk("nobyp2_reread", 32'(if2.DO), 32'h9);

    // CLR in IDLE, dropped write on the third clear edge, second CLR mid-sequence.
    if0.CLR = 1'b1;
    tick();
    if0.CLR = 1'b0;
    chk("clr_start_busy", 32'(if0.BUSY), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin if0.WRE = 1'b1; if0.WAD = 4'd0; if0.DI = 4'h5; end
      if (i == 5) if0.CLR = 1'b1;
      tick();
      if0.WRE = 1'b0; if0.CLR = 1'b0;
      if (i == 3) chk("drop_pulse", 32'(if0.DROP), 32'd1);
      if (i == 4) chk("drop_one_cycle", 32'(if0.DROP), 32'd0);
      if (i >= 15) chk($sformatf("reclr_busy_e%0d", i), 32'(if0.BUSY), 32'(i < 16));
    end
    for (int a = 0; a < 16; a++) begin
      if0.RAD = 4'(a);
      #1;
      chk($sformatf("reclr_sweep_%0d", a), 32'(if0.DO), 32'hA);
    end

    // Asynchronous reset landing at clr_ptr=8 on dut1.
    if1.CLR = 1'b1;
    tick();
    if1.CLR = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_do_hold", 32'(if1.DO), 32'h9);
    chk("pre_rst_busy", 32'(if1.BUSY), 32'd1);
    #2 rst1_n = 1'b0;
    #1;
    chk("async_rst_do", 32'(if1.DO), 32'd0);
    chk("async_rst_vld", 32'(if1.DO_VLD), 32'd0);
    chk("async_rst_busy", 32'(if1.BUSY), 32'd1);
    tick();
    rst1_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i >= 15) chk($sformatf("rst_reclr_busy_e%0d", i), 32'(if1.BUSY), 32'(i < 16));
    end
    if1.RE = 1'b1; if1.RAD = 4'd7;
    tick();
    chk("rst_reclr_w7", 32'(if1.DO), 32'h6);
    if1.RAD = 4'd8;
    tick();
    if1.RE = 1'b0;
    chk("rst_reclr_w8", 32'(if1.DO), 32'h6);

    // Random traffic on the 18x64 instance against a reference array.
    for (int a = 0; a < 64; a++) ref3[a] = 18'h2A5A5;
    exp_do3  = '0;
    exp_vld3 = 1'b0;
    for (int n = 0; n < 150; n++) begin
      if3.WRE = 1'($urandom_range(0, 1));
      if3.WAD = 6'($urandom_range(0, 63));
      if3.DI  = 18'($urandom);
      if3.RE  = 1'($urandom_range(0, 1));
      if3.RAD = (n % 5 == 0) ? if3.WAD : 6'($urandom_range(0, 63));
      exp_vld3 = if3.RE;
      if (if3.RE) exp_do3 = (if3.WRE && if3.WAD == if3.RAD) ? if3.DI : ref3[if3.RAD];
      if (if3.WRE) ref3[if3.WAD] = if3.DI;
      tick();
      chk($sformatf("rnd%0d_vld", n), 32'(if3.DO_VLD), 32'(exp_vld3));
      chk($sformatf("rnd%0d_do", n), 32'(if3.DO), 32'(exp_do3));
    end
    if3.WRE = 1'b0; if3.RE = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
